// File: rtl/interrupt_controller_n_if.sv
// rtl/interrupt_controller_n_if.sv - CPU-side request/response bundle of interrupt_controller_n
interface interrupt_controller_n_if #(
  parameter int NUM_SRC     = 4,
  parameter int PC_WIDTH    = 11,
  parameter int TIMER_WIDTH = 16
);
  logic [NUM_SRC-1:0]     i_irq_src;
  logic                   i_mask_we;
  logic [NUM_SRC-1:0]     i_mask_data;
  logic                   i_timer_set;
  logic [TIMER_WIDTH-1:0] i_timer_load;
  logic                   i_halt;
  logic [PC_WIDTH-1:0]    i_pc;
  logic                   i_ack;
  logic                   i_eret;
  logic                   o_int_take;
  logic [PC_WIDTH-1:0]    o_vector;
  logic [PC_WIDTH-1:0]    o_saved_pc;
  logic [31:0]            o_cause;
  logic                   o_in_service;

  modport master (
    output i_irq_src, i_mask_we, i_mask_data, i_timer_set, i_timer_load,
           i_halt, i_pc, i_ack, i_eret,
    input  o_int_take, o_vector, o_saved_pc, o_cause, o_in_service
  );

  modport slave (
    input  i_irq_src, i_mask_we, i_mask_data, i_timer_set, i_timer_load,
           i_halt, i_pc, i_ack, i_eret,
    output o_int_take, o_vector, o_saved_pc, o_cause, o_in_service
  );
endinterface

// File: rtl/interrupt_controller_n.sv
// rtl/interrupt_controller_n.sv - masked fixed-priority interrupt controller with quantum timer
// Optional INT_VECTOR_TABLE_EN: per-cause vectors at VECTOR_BASE + code*VECTOR_STRIDE.
module interrupt_controller_n #(
  parameter int NUM_SRC       = 4,
  parameter int PC_WIDTH      = 11,
  parameter int TIMER_WIDTH   = 16,
  parameter int VECTOR_BASE   = 0,
  parameter int VECTOR_STRIDE = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  interrupt_controller_n_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_SERVICE = 1'b1} state_t;

  state_t                 r_state;
  logic                   r_halt_pend;
  logic                   r_timer_pend;
  logic                   r_timer_en;
  logic [NUM_SRC-1:0]     r_src_pend;
  logic [NUM_SRC-1:0]     r_mask;
  logic [NUM_SRC-1:0]     r_irq_prev;
  logic [TIMER_WIDTH-1:0] r_quantum;
  logic [TIMER_WIDTH-1:0] r_count;
  logic [PC_WIDTH-1:0]    r_saved_pc;
  logic [31:0]            r_cause;

  logic [NUM_SRC-1:0]     w_src_elig;
  logic [NUM_SRC-1:0]     w_src_rise;
  logic [NUM_SRC-1:0]     w_src_clr;
  logic                   w_timer_elig;
  logic                   w_any_elig;
  logic                   w_take;
  logic                   w_clr_halt;
  logic                   w_clr_timer;
  logic                   w_timer_fire;
  logic [31:0]            w_code;
  logic [PC_WIDTH-1:0]    w_vector;

  assign w_src_elig   = r_src_pend & r_mask;
  assign w_src_rise   = bus.i_irq_src & ~r_irq_prev;
  assign w_timer_elig = r_timer_pend & r_timer_en;
  assign w_any_elig   = r_halt_pend | w_timer_elig | (|w_src_elig);
  // Take decision depends on registers only, so no input reaches int_take combinationally.
  assign w_take       = (r_state == S_IDLE) & w_any_elig;
  assign w_clr_halt   = w_take & r_halt_pend;
  assign w_clr_timer  = w_take & ~r_halt_pend & w_timer_elig;
  assign w_timer_fire = ~bus.i_timer_set & r_timer_en & (r_state == S_IDLE) &
                        (r_count == TIMER_WIDTH'(1));

  always_comb begin
    w_code    = 32'd0;
    w_src_clr = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_src_elig[i]) begin
        w_code       = 32'(3 + i);
        w_src_clr    = '0;
        w_src_clr[i] = 1'b1;
      end
    end
    if (w_timer_elig) begin
      w_code    = 32'd1;
      w_src_clr = '0;
    end
    if (r_halt_pend) begin
      w_code    = 32'd2;
      w_src_clr = '0;
    end
    if (!w_take) begin
      w_src_clr = '0;
    end
  end

`ifdef INT_VECTOR_TABLE_EN
  logic [PC_WIDTH-1:0] r_vector;
  logic [PC_WIDTH-1:0] w_vec_calc;

  assign w_vec_calc = PC_WIDTH'(32'(VECTOR_BASE) + w_code * 32'(VECTOR_STRIDE));
  assign w_vector   = (r_state == S_IDLE) ? w_vec_calc : r_vector;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vector <= PC_WIDTH'(VECTOR_BASE);
    end else if (w_take) begin
      r_vector <= w_vec_calc;
    end
  end
`else
  logic [31:0] w_unused_stride;

  assign w_unused_stride = 32'(VECTOR_STRIDE);
  assign w_vector        = PC_WIDTH'(VECTOR_BASE);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_halt_pend  <= 1'b0;
      r_timer_pend <= 1'b0;
      r_timer_en   <= 1'b0;
      r_src_pend   <= '0;
      r_mask       <= '0;
      r_irq_prev   <= '0;
      r_quantum    <= '0;
      r_count      <= '0;
      r_saved_pc   <= '0;
      r_cause      <= 32'd0;
    end else begin
      // Clears come from the take decision; new requests on the same edge win.
      r_irq_prev  <= bus.i_irq_src;
      r_src_pend  <= (r_src_pend & ~w_src_clr) | w_src_rise;
      r_halt_pend <= (r_halt_pend & ~w_clr_halt) | bus.i_halt;

      if (bus.i_mask_we) begin
        r_mask <= bus.i_mask_data;
      end

      if (bus.i_timer_set) begin
        r_quantum  <= bus.i_timer_load;
        r_count    <= bus.i_timer_load;
        r_timer_en <= |bus.i_timer_load;
        if (bus.i_timer_load == '0) begin
          r_timer_pend <= 1'b0;
        end else begin
          r_timer_pend <= r_timer_pend & ~w_clr_timer;
        end
      end else begin
        r_timer_pend <= (r_timer_pend & ~w_clr_timer) | w_timer_fire;
        if (r_timer_en && r_state == S_IDLE) begin
          r_count <= (r_count == TIMER_WIDTH'(1)) ? r_quantum : r_count - TIMER_WIDTH'(1);
        end
      end

      if (bus.i_ack) begin
        r_cause <= 32'd0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_state    <= S_SERVICE;
            r_saved_pc <= bus.i_pc;
            r_cause    <= w_code;
          end
        end
        S_SERVICE: begin
          if (bus.i_eret) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_int_take   = w_take;
  assign bus.o_vector     = w_vector;
  assign bus.o_saved_pc   = r_saved_pc;
  assign bus.o_cause      = r_cause;
  assign bus.o_in_service = (r_state == S_SERVICE);

endmodule

// File: tb/tb_interrupt_controller_n.sv
// tb/tb_interrupt_controller_n.sv - directed and randomized bench for interrupt_controller_n
module tb_interrupt_controller_n;
  localparam int NS = 4;
  localparam int PW = 11;
  localparam int TW = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  interrupt_controller_n_if #(.NUM_SRC(NS), .PC_WIDTH(PW), .TIMER_WIDTH(TW)) bus ();

  interrupt_controller_n #(
    .NUM_SRC(NS), .PC_WIDTH(PW), .TIMER_WIDTH(TW), .VECTOR_BASE(0), .VECTOR_STRIDE(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending sets, an idle-cycle counter for the timer, service flag.
  int      m_quantum;
  int      m_idle;
  bit      m_tpend;
  bit      m_halt;
  bit      m_service;
  bit [3:0] m_spend;
  bit [3:0] m_mask;
  bit [3:0] m_prev;
  int      m_saved;
  int      m_cause;
  int      m_vec;

  function automatic int m_winner();
    if (m_halt) return 2;
    if (m_quantum != 0 && m_tpend) return 1;
    for (int i = 0; i < NS; i++) if (m_spend[i] && m_mask[i]) return 3 + i;
    return 0;
  endfunction

  function automatic bit exp_take();
    return !m_service && (m_winner() != 0);
  endfunction

  function automatic int exp_vector();
`ifdef INT_VECTOR_TABLE_EN
    return m_service ? m_vec : ((m_winner() * 4) % 2048);
`else
    return 0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    int  w;
    bit  take;
    bit  was_idle;
    if (rst) begin
      m_quantum = 0; m_idle = 0; m_tpend = 0; m_halt = 0; m_service = 0;
      m_spend = '0; m_mask = '0; m_prev = '0; m_saved = 0; m_cause = 0; m_vec = 0;
    end else begin
      w        = m_winner();
      take     = !m_service && (w != 0);
      was_idle = !m_service;
      if (bus.i_ack) m_cause = 0;
      if (take) begin
        m_saved = int'(bus.i_pc);
        m_cause = w;
        m_vec   = (w * 4) % 2048;
        if (w == 2) m_halt = 0;
        else if (w == 1) m_tpend = 0;
        else m_spend[w-3] = 1'b0;
      end
      if (bus.i_timer_set) begin
        m_quantum = int'(bus.i_timer_load);
        m_idle    = 0;
        if (m_quantum == 0) m_tpend = 0;
      end else if (m_quantum != 0 && was_idle) begin
        m_idle++;
        if (m_idle == m_quantum) begin
          m_tpend = 1;
          m_idle  = 0;
        end
      end
      if (bus.i_halt) m_halt = 1;
      m_spend = m_spend | (bus.i_irq_src & ~m_prev);
      m_prev  = bus.i_irq_src;
      if (bus.i_mask_we) m_mask = bus.i_mask_data;
      if (take) m_service = 1;
      else if (m_service && bus.i_eret) m_service = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.i_irq_src = '0; bus.i_mask_we = 0; bus.i_mask_data = '0; bus.i_timer_set = 0;
    bus.i_timer_load = '0; bus.i_halt = 0; bus.i_pc = '0; bus.i_ack = 0; bus.i_eret = 0;
  endtask

  task automatic finish_service();
    bus.i_ack = 1; bus.i_eret = 1;
    step();
    bus.i_ack = 0; bus.i_eret = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    repeat (3) step();
    n_checks += 5;
    if (bus.o_int_take !== 1'b0) begin n_errors++; $display("FAIL reset_take got %0b want 0", bus.o_int_take); end
    if (bus.o_vector !== 11'd0) begin n_errors++; $display("FAIL reset_vector got %0d want 0", bus.o_vector); end
    if (bus.o_saved_pc !== 11'd0) begin n_errors++; $display("FAIL reset_saved_pc got %0d want 0", bus.o_saved_pc); end
    if (bus.o_cause !== 32'd0) begin n_errors++; $display("FAIL reset_cause got %0d want 0", bus.o_cause); end
    if (bus.o_in_service !== 1'b0) begin n_errors++; $display("FAIL reset_in_service got %0b want 0", bus.o_in_service); end
    rst = 0;
    step();
  endtask

  task automatic test_irq_basic();
    bus.i_mask_we = 1; bus.i_mask_data = 4'b0001;
    step();
    bus.i_mask_we = 0;
    bus.i_irq_src = 4'b0001; bus.i_pc = 11'd100;
    step();
    n_checks += 2;
    if (bus.o_int_take !== 1'b1) begin n_errors++; $display("FAIL irq0_take got %0b want 1", bus.o_int_take); end
    if (bus.o_in_service !== 1'b0) begin n_errors++; $display("FAIL irq0_pre_service got %0b want 0", bus.o_in_service); end
    step();
    n_checks += 4;
    if (bus.o_int_take !== 1'b0) begin n_errors++; $display("FAIL irq0_take_once got %0b want 0", bus.o_int_take); end
    if (bus.o_saved_pc !== 11'd100) begin n_errors++; $display("FAIL irq0_saved_pc got %0d want 100", bus.o_saved_pc); end
    if (bus.o_cause !== 32'd3) begin n_errors++; $display("FAIL irq0_cause got %0d want 3", bus.o_cause); end
    if (bus.o_in_service !== 1'b1) begin n_errors++; $display("FAIL irq0_in_service got %0b want 1", bus.o_in_service); end
    bus.i_irq_src = '0; bus.i_ack = 1;
    step();
    bus.i_ack = 0;
    n_checks += 2;
    if (bus.o_cause !== 32'd0) begin n_errors++; $display("FAIL irq0_ack_cause got %0d want 0", bus.o_cause); end
    if (bus.o_in_service !== 1'b1) begin n_errors++; $display("FAIL irq0_ack_service got %0b want 1", bus.o_in_service); end
    bus.i_eret = 1;
    step();
    bus.i_eret = 0;
    n_checks += 2;
    if (bus.o_in_service !== 1'b0) begin n_errors++; $display("FAIL irq0_eret_service got %0b want 0", bus.o_in_service); end
    if (bus.o_int_take !== 1'b0) begin n_errors++; $display("FAIL irq0_eret_take got %0b want 0", bus.o_int_take); end
  endtask

  task automatic test_halt_priority();
    bus.i_mask_we = 1; bus.i_mask_data = 4'b1111;
    step();
    bus.i_mask_we = 0;
    bus.i_irq_src = 4'b0100; bus.i_halt = 1;
    step();
    bus.i_halt = 0;
    step();
    n_checks += 2;
    if (bus.o_cause !== 32'd2) begin n_errors++; $display("FAIL prio_first_cause got %0d want 2", bus.o_cause); end
    if (bus.o_in_service !== 1'b1) begin n_errors++; $display("FAIL prio_first_service got %0b want 1", bus.o_in_service); end
    bus.i_eret = 1;
    step();
    bus.i_eret = 0;
    n_checks += 1;
    if (bus.o_int_take !== 1'b1) begin n_errors++; $display("FAIL prio_zero_gap_take got %0b want 1", bus.o_int_take); end
    step();
    n_checks += 2;
    if (bus.o_cause !== 32'd5) begin n_errors++; $display("FAIL prio_second_cause got %0d want 5", bus.o_cause); end
    if (bus.o_in_service !== 1'b1) begin n_errors++; $display("FAIL prio_second_service got %0b want 1", bus.o_in_service); end
    bus.i_irq_src = '0;
    finish_service();
    n_checks += 2;
    if (bus.o_cause !== 32'd0) begin n_errors++; $display("FAIL ack_eret_cause got %0d want 0", bus.o_cause); end
    if (bus.o_in_service !== 1'b0) begin n_errors++; $display("FAIL ack_eret_service got %0b want 0", bus.o_in_service); end
  endtask

  task automatic test_timer();
    bus.i_timer_set = 1; bus.i_timer_load = 16'd5;
    step();
    bus.i_timer_set = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if (bus.o_int_take !== (k == 5)) begin n_errors++; $display("FAIL timer_period cycle %0d got %0b want %0b", k, bus.o_int_take, (k == 5)); end
    end
    step();
    n_checks += 2;
    if (bus.o_cause !== 32'd1) begin n_errors++; $display("FAIL timer_cause got %0d want 1", bus.o_cause); end
    if (bus.o_in_service !== 1'b1) begin n_errors++; $display("FAIL timer_service got %0b want 1", bus.o_in_service); end
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if (bus.o_int_take !== 1'b0) begin n_errors++; $display("FAIL timer_service_take cycle %0d got %0b want 0", k, bus.o_int_take); end
    end
    bus.i_eret = 1;
    step();
    bus.i_eret = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (bus.o_int_take !== (k == 4)) begin n_errors++; $display("FAIL timer_frozen cycle %0d got %0b want %0b", k, bus.o_int_take, (k == 4)); end
    end
    bus.i_timer_set = 1; bus.i_timer_load = 16'd0;
    step();
    bus.i_timer_set = 0;
    finish_service();
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (bus.o_int_take !== 1'b0) begin n_errors++; $display("FAIL timer_disabled cycle %0d got %0b want 0", k, bus.o_int_take); end
    end
  endtask

  task automatic test_mask();
    bus.i_mask_we = 1; bus.i_mask_data = 4'b0000;
    step();
    bus.i_mask_we = 0;
    bus.i_irq_src = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (bus.o_int_take !== 1'b0) begin n_errors++; $display("FAIL mask_block cycle %0d got %0b want 0", k, bus.o_int_take); end
    end
    bus.i_mask_we = 1; bus.i_mask_data = 4'b0010;
    step();
    bus.i_mask_we = 0;
    n_checks++;
    if (bus.o_int_take !== 1'b1) begin n_errors++; $display("FAIL mask_unblock_take got %0b want 1", bus.o_int_take); end
    step();
    n_checks++;
    if (bus.o_cause !== 32'd4) begin n_errors++; $display("FAIL mask_cause got %0d want 4", bus.o_cause); end
    bus.i_irq_src = '0;
    finish_service();
  endtask

  task automatic test_vector();
    int exp_v;
`ifdef INT_VECTOR_TABLE_EN
    exp_v = 8;
`else
    exp_v = 0;
`endif
    bus.i_halt = 1;
    step();
    bus.i_halt = 0;
    n_checks += 2;
    if (bus.o_int_take !== 1'b1) begin n_errors++; $display("FAIL vector_take got %0b want 1", bus.o_int_take); end
    if (bus.o_vector !== 11'(exp_v)) begin n_errors++; $display("FAIL vector_idle got %0d want %0d", bus.o_vector, exp_v); end
    step();
    n_checks += 2;
    if (bus.o_vector !== 11'(exp_v)) begin n_errors++; $display("FAIL vector_held got %0d want %0d", bus.o_vector, exp_v); end
    if (bus.o_cause !== 32'd2) begin n_errors++; $display("FAIL vector_cause got %0d want 2", bus.o_cause); end
    finish_service();
  endtask

  task automatic test_random();
    bus.i_timer_set = 1; bus.i_timer_load = 16'd7;
    step();
    bus.i_timer_set = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NS; i++) if ($urandom_range(0, 5) == 0) bus.i_irq_src[i] = ~bus.i_irq_src[i];
      bus.i_halt      = ($urandom_range(0, 19) == 0);
      bus.i_mask_we   = ($urandom_range(0, 7) == 0);
      bus.i_mask_data = 4'($urandom_range(0, 15));
      bus.i_timer_set = ($urandom_range(0, 29) == 0);
      bus.i_timer_load = 16'($urandom_range(0, 12));
      bus.i_pc        = 11'($urandom_range(0, 2047));
      bus.i_ack       = ($urandom_range(0, 5) == 0);
      bus.i_eret      = ($urandom_range(0, 3) == 0);
      step();
      n_checks += 5;
      if (bus.o_int_take !== exp_take()) begin n_errors++; $display("FAIL rand_take cycle %0d got %0b want %0b", c, bus.o_int_take, exp_take()); end
      if (bus.o_in_service !== m_service) begin n_errors++; $display("FAIL rand_service cycle %0d got %0b want %0b", c, bus.o_in_service, m_service); end
      if (bus.o_cause !== 32'(m_cause)) begin n_errors++; $display("FAIL rand_cause cycle %0d got %0d want %0d", c, bus.o_cause, m_cause); end
      if (bus.o_saved_pc !== 11'(m_saved)) begin n_errors++; $display("FAIL rand_saved_pc cycle %0d got %0d want %0d", c, bus.o_saved_pc, m_saved); end
      if (bus.o_vector !== 11'(exp_vector())) begin n_errors++; $display("FAIL rand_vector cycle %0d got %0d want %0d", c, bus.o_vector, exp_vector()); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_service();
    bus.i_eret = 1; bus.i_ack = 1;
    step();
    bus.i_eret = 0; bus.i_ack = 0;
    repeat (4) begin
      if (bus.o_int_take || bus.o_in_service) finish_service();
    end
    bus.i_timer_set = 1; bus.i_timer_load = 16'd0;
    bus.i_mask_we = 1; bus.i_mask_data = 4'b0001;
    step();
    bus.i_timer_set = 0; bus.i_mask_we = 0;
    finish_service();
    bus.i_irq_src = 4'b0001; bus.i_pc = 11'd37;
    step();
    step();
    n_checks += 2;
    if (bus.o_saved_pc !== 11'd37) begin n_errors++; $display("FAIL midrst_setup_pc got %0d want 37", bus.o_saved_pc); end
    if (bus.o_in_service !== 1'b1) begin n_errors++; $display("FAIL midrst_setup_service got %0b want 1", bus.o_in_service); end
    #2;
    rst = 1;
    bus.i_irq_src = '0;
    #1;
    n_checks += 4;
    if (bus.o_in_service !== 1'b0) begin n_errors++; $display("FAIL midrst_service got %0b want 0", bus.o_in_service); end
    if (bus.o_cause !== 32'd0) begin n_errors++; $display("FAIL midrst_cause got %0d want 0", bus.o_cause); end
    if (bus.o_saved_pc !== 11'd0) begin n_errors++; $display("FAIL midrst_saved_pc got %0d want 0", bus.o_saved_pc); end
    if (bus.o_int_take !== 1'b0) begin n_errors++; $display("FAIL midrst_take got %0b want 0", bus.o_int_take); end
    @(negedge clk);
    rst = 0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_irq_basic();
    test_halt_priority();
    test_timer();
    test_mask();
    test_vector();
    test_random();
    test_reset_mid_service();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/interrupt_controller_n.md
Name: interrupt_controller_n

Overview:
- Parametrised successor to the two-source (halt/timer) interrupt logic of the single-cycle MIPS core.
- Generalises it to NUM_SRC external request lines with per-source mask, a programmable quantum timer, fixed priority, a saved-PC buffer and a cause register.
- Sits beside PCVersion2: redirects the PC to a vector, holds the return PC for savePCBuffer, and exposes the cause for getInterruption.

Parameters:
- NUM_SRC, 4, number of external interrupt request lines.
- PC_WIDTH, 11, width of instruction addresses.
- TIMER_WIDTH, 16, width of timer quantum/counter.
- VECTOR_BASE, 0, PC of the interrupt handler entry.
- VECTOR_STRIDE, 4, spacing between per-cause vectors (used only with INT_VECTOR_TABLE_EN).

Ports:
- Clock  in  1  CPU clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high.
- irq_src  in  NUM_SRC  external requests; rising edges are latched.
- mask_we  in  1  write enable for the mask register.
- mask_data  in  NUM_SRC  new mask value; 1 = source enabled.
- timer_set  in  1  load timer quantum (setClock).
- timer_load  in  TIMER_WIDTH  quantum in cycles; 0 disables the timer.
- halt  in  1  halt request (halt instruction).
- pc  in  PC_WIDTH  next-PC candidate from the jump/branch mux.
- ack  in  1  getInterruption: the cause is consumed.
- eret  in  1  handler finished; re-arm the controller.
- int_take  out  1  force PC := vector in this cycle.
- vector  out  PC_WIDTH  handler address.
- saved_pc  out  PC_WIDTH  return address captured at take.
- cause  out  32  0 none, 1 timer, 2 halt, 3+i irq_src[i].
- in_service  out  1  handler active.

Behaviour:
- Reset (async): state IDLE, all pending 0, mask 0, irq_src history 0, timer disabled/count 0. Outputs: int_take 0, vector VECTOR_BASE, saved_pc 0, cause 0, in_service 0.
- Pending latching:
  - halt=1 sets halt_pend.
  - A 0→1 on irq_src[i], vs the previous-cycle register, sets src_pend[i]. Latching ignores the mask.
  - Pending bits latch in any state.
  - Set and clear of the same bit on the same edge: set wins.
- Eligibility:
  - halt_pend is always eligible.
  - timer_pend is eligible while the timer is enabled.
  - src_pend[i] is eligible only when mask[i]=1.
- Priority: halt > timer > irq_src[0] > … > irq_src[NUM_SRC-1].
- State machine (2 states):
  - IDLE: int_take = any eligible (combinational from registers only, no input paths). On an edge with int_take=1: saved_pc<=pc, cause<=code of the winner, winner's pending cleared, state<=SERVICE.
  - SERVICE: int_take=0, in_service=1. eret → IDLE on the next edge. No nesting; halt during SERVICE waits until after eret.
  - After eret, a still-eligible pending is taken in the first IDLE cycle (zero gap).
- ack: cause<=0 on the next edge. If ack and eret coincide, both apply.
- Timer:
  - timer_set loads count<=timer_load; timer_load=0 disables the timer and clears timer_pend.
  - The count decrements only in IDLE.
  - Reaching 1 sets timer_pend and reloads the quantum.
  - timer_set in the same cycle as expiry: the load wins and no pending is generated.
- Mask: mask_we updates on the edge and takes effect for int_take in the following cycle. Masking a pending source keeps it pending.

Optional Feature:
- INT_VECTOR_TABLE_EN defined: vector = VECTOR_BASE + winner_code*VECTOR_STRIDE, truncated to PC_WIDTH. In SERVICE, vector holds the last taken value.
- Undefined: vector = VECTOR_BASE always; the handler dispatches by reading cause.

Test Plan:
- Reset mid-SERVICE with saved_pc=37 → immediately in_service=0, cause=0, saved_pc=0, int_take=0.
- mask=4'b0001, irq_src[0] rises while pc=100 → int_take=1 for one cycle, then saved_pc=100, cause=3, in_service=1; ack → cause=0; eret → IDLE.
- irq_src[2] and halt rise in the same cycle, mask=4'b1111 → cause=2 first; after eret, cause=5 taken the next cycle with no gap.
- timer_load=5 with timer_set, no other events → int_take every 5 IDLE cycles, cause=1; counter frozen during SERVICE.
- irq_src[1] edge with mask=0 → no int_take; write mask=4'b0010 → int_take the cycle after, cause=4.
- With INT_VECTOR_TABLE_EN, VECTOR_BASE=0, STRIDE=4, halt → vector=8; without the macro → vector=0.
